// File: rtl/ctrl_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | ctrl_pkg : shared types and defaults for the exposure sequencer      |
// | Rev 1.0  : initial release                                          |
// +---------------------------------------------------------------------+
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ERASE  = 3'd1,
    EXPOSE = 3'd2,
    READ1  = 3'd3,
    READ2  = 3'd4
  } state_t;

  localparam int DEF_EXP_W     = 5;
  localparam int DEF_EXP_MIN   = 2;
  localparam int DEF_EXP_MAX   = 30;
  localparam int DEF_ERASE_CYC = 2;
  localparam int DEF_READ_CYC  = 2;
  localparam int CNT_W         = 5;

  function automatic logic [CNT_W-1:0] clamp_exp(input int val, input int lo, input int hi);
    int v;
    v = (val < lo) ? lo : ((val > hi) ? hi : val);
    return CNT_W'(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_exposure_seq_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | ctrl_exposure_seq_if : request inputs and pixel-array control lines |
// | Optional Abort line when CTRL_EXP_ABORT_EN is defined               |
// | Rev 1.0  : initial release                                          |
// +---------------------------------------------------------------------+
interface ctrl_exposure_seq_if #(parameter int EXP_W = 5);
  logic             Init;
  logic [EXP_W-1:0] EX_time;
`ifdef CTRL_EXP_ABORT_EN
  logic             Abort;
`endif
  logic             Erase;
  logic             Expose;
  logic             NRE_1;
  logic             NRE_2;
  logic             ADC;
  logic             Busy;
  logic             Done;

  modport master (
`ifdef CTRL_EXP_ABORT_EN
    output Abort,
`endif
    output Init, EX_time,
    input  Erase, Expose, NRE_1, NRE_2, ADC, Busy, Done
  );

  modport slave (
`ifdef CTRL_EXP_ABORT_EN
    input  Abort,
`endif
    input  Init, EX_time,
    output Erase, Expose, NRE_1, NRE_2, ADC, Busy, Done
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_cycle_counter.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | ctrl_cycle_counter : loadable saturating down-counter with zero flag|
// | Rev 1.0  : initial release                                          |
// +---------------------------------------------------------------------+
module ctrl_cycle_counter
  import ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  wire logic         Clk,
  input  wire logic         Reset,
  input  wire logic         load,
  input  wire logic [W-1:0] load_val,
  output logic      [W-1:0] count,
  output logic              zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/ctrl_exposure_seq.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | ctrl_exposure_seq : erase / expose / two-row readout sequencer      |
// | Optional macro CTRL_EXP_ABORT_EN adds the Abort input               |
// | Rev 1.0  : initial release                                          |
// +---------------------------------------------------------------------+
module ctrl_exposure_seq
  import ctrl_pkg::*;
#(
  parameter int EXP_W     = DEF_EXP_W,
  parameter int EXP_MIN   = DEF_EXP_MIN,
  parameter int EXP_MAX   = DEF_EXP_MAX,
  parameter int ERASE_CYC = DEF_ERASE_CYC,
  parameter int READ_CYC  = DEF_READ_CYC
) (
  input wire logic           Clk,
  input wire logic           Reset,
  ctrl_exposure_seq_if.slave bus
);

  state_t           state, state_nx;
  logic             load, latch, abort;
  logic [CNT_W-1:0] load_val, count, exp_q;
  logic             zero, cnt_nx_zero;
  logic [EXP_W-1:0] ex_time;

  logic erase_q, expose_q, nre1_q, nre2_q, adc_q, busy_q, done_q;
  logic erase_nx, expose_nx, nre1_nx, nre2_nx, adc_nx, busy_nx, done_nx;

  assign ex_time = bus.EX_time;

`ifdef CTRL_EXP_ABORT_EN
  assign abort = bus.Abort;
`else
  assign abort = 1'b0;
`endif

  ctrl_cycle_counter #(.W(CNT_W)) u_cnt (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .zero     (zero)
  );

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_val = '0;
    latch    = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Init && !abort) begin
          state_nx = ERASE;
          load     = 1'b1;
          load_val = CNT_W'(ERASE_CYC - 1);
          latch    = 1'b1;
        end
      end
      ERASE: begin
        if (zero) begin
          state_nx = EXPOSE;
          load     = 1'b1;
          load_val = exp_q - 1'b1;
        end
      end
      EXPOSE: begin
        if (zero) begin
          state_nx = READ1;
          load     = 1'b1;
          load_val = CNT_W'(READ_CYC - 1);
        end
      end
      READ1: begin
        if (zero) begin
          state_nx = READ2;
          load     = 1'b1;
          load_val = CNT_W'(READ_CYC - 1);
        end
      end
      READ2: begin
        if (zero) begin
          done_nx = 1'b1;
          // A held Init chains straight into the next erase with no idle gap
          if (bus.Init && !abort) begin
            state_nx = ERASE;
            load     = 1'b1;
            load_val = CNT_W'(ERASE_CYC - 1);
            latch    = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        load     = 1'b1;
      end
    endcase

    if (abort && (state != IDLE)) begin
      state_nx = IDLE;
      load     = 1'b1;
      load_val = '0;
      latch    = 1'b0;
      done_nx  = 1'b0;
    end

    // Registered outputs are decoded from where the FSM is going next
    cnt_nx_zero = load ? (load_val == '0) : (count <= CNT_W'(1));
    erase_nx    = (state_nx == IDLE) || (state_nx == ERASE);
    expose_nx   = (state_nx == EXPOSE);
    nre1_nx     = (state_nx != READ1);
    nre2_nx     = (state_nx != READ2);
    adc_nx      = ((state_nx == READ1) || (state_nx == READ2)) && cnt_nx_zero;
    busy_nx     = (state_nx != IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      exp_q    <= CNT_W'(EXP_MIN);
      erase_q  <= 1'b1;
      expose_q <= 1'b0;
      nre1_q   <= 1'b1;
      nre2_q   <= 1'b1;
      adc_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      if (latch) begin
        exp_q <= clamp_exp(int'(ex_time), EXP_MIN, EXP_MAX);
      end
      erase_q  <= erase_nx;
      expose_q <= expose_nx;
      nre1_q   <= nre1_nx;
      nre2_q   <= nre2_nx;
      adc_q    <= adc_nx;
      busy_q   <= busy_nx;
      done_q   <= done_nx;
    end
  end

  assign bus.Erase  = erase_q;
  assign bus.Expose = expose_q;
  assign bus.NRE_1  = nre1_q;
  assign bus.NRE_2  = nre2_q;
  assign bus.ADC    = adc_q;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;

endmodule
`default_nettype wire
